// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU op encodings, FSM state codes, result payload and op classifiers.
// Optional build macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU as launch ops.
package mdu_ctrl_pkg;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t MDUOP_NONE  = 4'd0;
  localparam mdu_op_t MDUOP_MULT  = 4'd1;
  localparam mdu_op_t MDUOP_MULTU = 4'd2;
  localparam mdu_op_t MDUOP_DIV   = 4'd3;
  localparam mdu_op_t MDUOP_DIVU  = 4'd4;
  localparam mdu_op_t MDUOP_MFHI  = 4'd5;
  localparam mdu_op_t MDUOP_MFLO  = 4'd6;
  localparam mdu_op_t MDUOP_MTHI  = 4'd7;
  localparam mdu_op_t MDUOP_MTLO  = 4'd8;
  localparam mdu_op_t MDUOP_MADD  = 4'd9;
  localparam mdu_op_t MDUOP_MADDU = 4'd10;
  localparam mdu_op_t MDUOP_MSUB  = 4'd11;
  localparam mdu_op_t MDUOP_MSUBU = 4'd12;

  localparam logic [0:0] MDU_IDLE = 1'b0;
  localparam logic [0:0] MDU_RUN  = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  function automatic logic is_div(input mdu_op_t op);
    return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
  endfunction

  // Ops that occupy the sequencer; accumulate ops only exist in the MADD build.
  function automatic logic is_launch(input mdu_op_t op);
    logic l;
    l = (op == MDUOP_MULT) || (op == MDUOP_MULTU) || is_div(op);
`ifdef MDU_MADD_EN
    l = l || (op == MDUOP_MADD) || (op == MDUOP_MADDU) ||
             (op == MDUOP_MSUB) || (op == MDUOP_MSUBU);
`endif
    return l;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Handshake/data bundle between the EX stage (master) and the MDU (slave).
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic [31:0] A;
  logic [31:0] B;
  mdu_op_t     mdu_op;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] out;

  modport master (output A, B, mdu_op, start, input busy, HI, LO, out);
  modport slave  (input A, B, mdu_op, start, output busy, HI, LO, out);
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational MDU datapath: latched op/operands (+ HI/LO for accumulate) to {hi,lo}.
module mdu_ctrl_arith
  import mdu_ctrl_pkg::*;
(
  input  mdu_op_t     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output mdu_res_t    o_res_c,
  output logic        o_commit_c
);

  logic [63:0] w_prod_s, w_prod_u, w_acc;
  logic [31:0] w_b_nz, w_abs_a, w_abs_b, w_uq, w_ur, w_sq, w_sr, w_q, w_r;

  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
  assign w_acc    = {i_hi, i_lo};

  // Guard the divisor so zero never reaches the divider; commit is suppressed instead.
  assign w_b_nz  = (i_b == 32'd0) ? 32'd1 : i_b;
  assign w_abs_a = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_abs_b = w_b_nz[31] ? (32'd0 - w_b_nz) : w_b_nz;
  assign w_uq    = w_abs_a / w_abs_b;
  assign w_ur    = w_abs_a % w_abs_b;
  assign w_sq    = (i_a[31] ^ w_b_nz[31]) ? (32'd0 - w_uq) : w_uq;
  assign w_sr    = i_a[31] ? (32'd0 - w_ur) : w_ur;
  assign w_q     = w_b_nz / w_b_nz * 32'd0 + (i_a / w_b_nz);
  assign w_r     = i_a % w_b_nz;

  always_comb begin
    o_res_c    = '0;
    o_commit_c = 1'b1;
    case (i_op)
      MDUOP_MULT:  o_res_c = w_prod_s;
      MDUOP_MULTU: o_res_c = w_prod_u;
      MDUOP_DIV:   begin o_res_c.lo = w_sq; o_res_c.hi = w_sr; o_commit_c = (i_b != 32'd0); end
      MDUOP_DIVU:  begin o_res_c.lo = w_q;  o_res_c.hi = w_r;  o_commit_c = (i_b != 32'd0); end
      MDUOP_MADD:  o_res_c = w_acc + w_prod_s;
      MDUOP_MADDU: o_res_c = w_acc + w_prod_u;
      MDUOP_MSUB:  o_res_c = w_acc - w_prod_s;
      MDUOP_MSUBU: o_res_c = w_acc - w_prod_u;
      default:     o_commit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; fixed latency per op class.
// Build macro MDU_MADD_EN (see mdu_ctrl_pkg) adds MADD/MADDU/MSUB/MSUBU launches.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_ctrl_if.slave   bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nx;
  logic [31:0]      r_a, w_a_nx, r_b, w_b_nx, r_hi, w_hi_nx, r_lo, w_lo_nx;
  mdu_op_t          r_op,    w_op_nx;
  logic             r_busy,  w_busy_nx;
  mdu_res_t         w_res;
  logic             w_commit;

  mdu_ctrl_arith u_arith (
    .i_op       (r_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .o_res_c    (w_res),
    .o_commit_c (w_commit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= MDUOP_NONE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_op    <= w_op_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_busy  <= w_busy_nx;
    end
  end

  // Counter loaded with N and committing at count 1 gives exactly N busy cycles.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_op_nx    = r_op;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_busy_nx  = r_busy;
    case (r_state)
      MDU_IDLE: begin
        if (bus.start && is_launch(bus.mdu_op)) begin
          w_a_nx     = bus.A;
          w_b_nx     = bus.B;
          w_op_nx    = bus.mdu_op;
          w_cnt_nx   = is_div(bus.mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          w_state_nx = MDU_RUN;
          w_busy_nx  = 1'b1;
        end else if (!bus.start) begin
          if (bus.mdu_op == MDUOP_MTHI) w_hi_nx = bus.A;
          if (bus.mdu_op == MDUOP_MTLO) w_lo_nx = bus.A;
        end
      end
      MDU_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          if (w_commit) begin
            w_hi_nx = w_res.hi;
            w_lo_nx = w_res.lo;
          end
          w_cnt_nx   = '0;
          w_state_nx = MDU_IDLE;
          w_busy_nx  = 1'b0;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = MDU_IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  assign bus.busy = r_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
  assign bus.out  = (bus.mdu_op == MDUOP_MFHI) ? r_hi :
                    (bus.mdu_op == MDUOP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: latency, arithmetic, MT/MF, ignores, reset.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt;

  always #5 clk = ~clk;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle start pulse; returns at the first negedge where busy should be high.
  task automatic launch(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.mdu_op = op; bus.A = a; bus.B = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = MDUOP_NONE;
  endtask

  // Count consecutive busy cycles from the current negedge, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mt(input mdu_op_t op, input logic [31:0] a);
    @(negedge clk);
    bus.mdu_op = op; bus.A = a; bus.start = 1'b0;
    @(negedge clk);
    bus.mdu_op = MDUOP_NONE;
  endtask

  initial begin
    bus.A = '0; bus.B = '0; bus.mdu_op = MDUOP_NONE; bus.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);

    // MULT -2 * 3
    launch(MDUOP_MULT, 32'hFFFF_FFFE, 32'd3);
    bus.A = 32'h5555_5555; bus.B = 32'h7;
    count_busy(cnt);
    check("mult_lat", cnt, 32'd5);
    check("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo", bus.LO, 32'hFFFF_FFFA);
    bus.mdu_op = MDUOP_MFHI; #1;
    check("mfhi_out", bus.out, 32'hFFFF_FFFF);
    bus.mdu_op = MDUOP_MFLO; #1;
    check("mflo_out", bus.out, 32'hFFFF_FFFA);
    bus.mdu_op = MDUOP_NONE; #1;
    check("none_out", bus.out, 32'd0);

    // DIVU / DIV
    launch(MDUOP_DIVU, 32'd17, 32'd5);
    count_busy(cnt);
    check("divu_lat", cnt, 32'd10);
    check("divu_lo", bus.LO, 32'd3);
    check("divu_hi", bus.HI, 32'd2);
    launch(MDUOP_DIV, 32'hFFFF_FFEF, 32'd5);
    count_busy(cnt);
    check("div_lo", bus.LO, 32'hFFFF_FFFD);
    check("div_hi", bus.HI, 32'hFFFF_FFFE);
    launch(MDUOP_DIV, 32'd100, 32'hFFFF_FFF9);
    count_busy(cnt);
    check("div_nb_lo", bus.LO, 32'hFFFF_FFF2);
    check("div_nb_hi", bus.HI, 32'd2);
    launch(MDUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(cnt);
    check("ovf_lo", bus.LO, 32'h8000_0000);
    check("ovf_hi", bus.HI, 32'd0);

    // MTLO then divide by zero leaves HI/LO untouched after a full-length run
    mt(MDUOP_MTLO, 32'h0000_1234);
    check("mtlo", bus.LO, 32'h0000_1234);
    launch(MDUOP_DIV, 32'd99, 32'd0);
    count_busy(cnt);
    check("dz_lat", cnt, 32'd10);
    check("dz_lo", bus.LO, 32'h0000_1234);
    check("dz_hi", bus.HI, 32'd0);
    mt(MDUOP_MTHI, 32'hCAFE_0001);
    check("mthi", bus.HI, 32'hCAFE_0001);

    // MTHI with start high and launch ops with start high in wrong op are ignored
    @(negedge clk);
    bus.mdu_op = MDUOP_MTHI; bus.A = 32'h0BAD_0BAD; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = MDUOP_NONE;
    check("mthi_start_busy", {31'd0, bus.busy}, 32'd0);
    check("mthi_start_hi", bus.HI, 32'hCAFE_0001);

    // MULTU with a restart attempt at busy cycle 2
    launch(MDUOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.mdu_op = MDUOP_MULTU; bus.A = 32'd1; bus.B = 32'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = MDUOP_NONE;
    count_busy(cnt);
    check("restart_lat", cnt + 2, 32'd5);
    check("multu_hi", bus.HI, 32'hFFFF_FFFE);
    check("multu_lo", bus.LO, 32'h0000_0001);

    // Reset in the middle of a divide discards it
    launch(MDUOP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_hi", bus.HI, 32'd0);
    check("mid_rst_lo", bus.LO, 32'd0);
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.busy === 1'b1) cnt++;
    end
    check("post_rst_busy", cnt, 32'd0);
    check("post_rst_lo", bus.LO, 32'd0);

    // Accumulate op: active only in the MADD build
    mt(MDUOP_MTLO, 32'hFFFF_FFFF);
    launch(MDUOP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    count_busy(cnt);
    check("maddu_lat", cnt, 32'd5);
    check("maddu_hi", bus.HI, 32'd1);
    check("maddu_lo", bus.LO, 32'd0);
`else
    cnt = 0;
    repeat (8) begin
      if (bus.busy === 1'b1) cnt++;
      @(negedge clk);
    end
    check("maddu_busy", cnt, 32'd0);
    check("maddu_hi", bus.HI, 32'd0);
    check("maddu_lo", bus.LO, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer with architectural HI/LO registers, sitting in EX beside the single-cycle ALU. It accepts one multiply or divide command per start pulse and holds busy for a fixed latency. It commits results to HI/LO and serves MFHI/MFLO reads. The hazard unit stalls any MDU instruction in D while start or busy is high.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; one clock; cleared on the rising edge where reset=1
A  in  32  rs operand (forwarded)
B  in  32  rt operand (forwarded)
mdu_op  in  4  operation select, MDUOP_* constants
start  in  1  EX-stage pulse: launch MULT/MULTU/DIV/DIVU in mdu_op
busy  out  1  operation in flight
HI  out  32  architectural HI register
LO  out  32  architectural LO register
out  out  32  read data: HI when mdu_op=MFHI, LO when MFLO, else 0 (combinational)

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0, state IDLE; any in-flight op is discarded without committing.
- States: IDLE, RUN.
- IDLE + start=1 + mdu_op in {MULT,MULTU,DIV,DIVU}:
  - latch A, B, op;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN next edge; busy=1 from the following cycle.
- RUN: counter decrements each cycle. On the edge where counter==1:
  - commit HI/LO;
  - return to IDLE; busy=0 the next cycle.
  - Total busy duration is exactly N cycles.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit A*B.
  - MULTU: unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of A.
  - DIVU: unsigned quotient/remainder.
  - 0x80000000 / -1: LO = 0x80000000, HI = 0.
- Divide by zero (B==0 for DIV/DIVU): runs the full DIV_CYCLES; HI/LO unchanged at commit.
- MTHI/MTLO: when mdu_op=MTHI/MTLO and start=0 and busy=0, write A to HI/LO at the next edge.
- start while busy: ignored; no restart and no operand relatch.
- MTHI/MTLO while busy: ignored. The hazard unit guarantees this cannot occur.
- start with a non-launch op: ignored.
- MFHI/MFLO during busy: `out` returns the stale register. The stall rule prevents this case.
- Operands are latched at start, so later changes on A/B do not affect the result.

Optional Feature:
MDU_MADD_EN
- Defined: adds MDUOP_MADD, MADDU, MSUB, MSUBU as launch ops with MULT_CYCLES latency.
  - Commit is {HI,LO} = {HI,LO} ± product (signed or unsigned), using the HI/LO values at commit time.
- Undefined: these encodings are treated as non-launch ops and are ignored.

Decomposition:
- Shared const.v `define constants:
  - MDUOP_NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU (4-bit);
  - MDU_IDLE, MDU_RUN.
- One natural sub-module, mdu_arith: purely combinational. Maps the latched op and operands (plus HI/LO for MADD) to a 64-bit {hi,lo} result and a commit-enable (0 for divide by zero).
- mdu_ctrl owns the FSM, counter, latches and HI/LO.

Test Plan:
- MULT with A=0xFFFFFFFE (-2), B=3, start 1 cycle → busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI out=0xFFFFFFFF.
- DIVU with A=17, B=5 → busy 10 cycles, then LO=3, HI=2. DIV with A=-17 (0xFFFFFFEF), B=5 → LO=0xFFFFFFFD, HI=0xFFFFFFFE.
- MTLO A=0x1234 then DIV with B=0 → busy 10 cycles, LO stays 0x1234, HI stays 0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF; second start at busy cycle 2 with A=1, B=1 → ignored; final HI=0xFFFFFFFE, LO=0x00000001.
- DIV in progress; reset asserted at busy cycle 4 → next cycle busy=0, HI=LO=0; no later commit.
- (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 → HI=1, LO=0. Without the macro, the same op → HI/LO unchanged and busy never rises.
